// File: rtl/dm_wait_pkg.sv
// dm_wait_pkg
// Shared definitions for the handshaked data memory: access-size encodings,
// FSM state codes, the captured-request record and a lane extension helper.
// No ports (package).

package dm_wait_pkg;

   // Access size as presented on the size input
   typedef enum logic [1:0] {
      DM_BYTE = 2'b00,
      DM_HALF = 2'b01,
      DM_WORD = 2'b10,
      DM_RSVD = 2'b11
   } dm_size_e;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } dm_state_e;

   // Width of the wait-state counter (LATENCY is limited to 0..15)
   localparam int CNT_W = 4;

   // Everything the requester presents, held from accept until the response
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dm_req_t;

   // Right-aligned byte or half widened to 32 bits, zero- or sign-extended
   function automatic logic [31:0] extend_lane(input logic [15:0] val,
                                               input logic        is_half,
                                               input logic        uns);
      logic [31:0] res;
      if (is_half) begin
         res = uns ? {16'h0000, val} : {{16{val[15]}}, val};
      end else begin
         res = uns ? {24'h000000, val[7:0]} : {{24{val[7]}}, val[7:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_wait_lane_align.sv
// dm_lane_align
// Purely combinational little-endian lane steering for the data memory.
// Ports:
//   size       in  2  access size (byte/half/word/reserved)
//   addr_lo    in  2  low address bits selecting the lane(s)
//   wdata      in  32 right-aligned store data
//   uns        in  1  zero-extend (1) or sign-extend (0) narrow loads
//   rword      in  32 raw word read from the array
//   lane_mask  out 4  byte lanes written by a store
//   store_word out 32 store data replicated onto its lanes
//   load_data  out 32 extracted, right-aligned and extended load result
//   misalign   out 1  half on an odd address or word not on a 4-byte boundary

module dm_lane_align
   import dm_wait_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic        uns,
   input  logic [31:0] rword,
   output logic [3:0]  lane_mask,
   output logic [31:0] store_word,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] byte_shifted;
   logic [15:0] half_sel;

   // Bring the addressed byte down to bit 0 and pick the addressed half.
   // Replicating the store data onto every lane lets the mask alone decide
   // which lanes actually change.
   always_comb begin
      byte_shifted = rword >> {addr_lo, 3'b000};
      half_sel     = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   // Per-size lane mask, store word, load extraction and alignment check.
   // The reserved size leaves everything at zero; the top flags it as a fault.
   always_comb begin
      lane_mask  = 4'b0000;
      store_word = 32'h0000_0000;
      load_data  = 32'h0000_0000;
      misalign   = 1'b0;
      case (size)
         DM_BYTE: begin
            lane_mask  = 4'b0001 << addr_lo;
            store_word = {4{wdata[7:0]}};
            load_data  = extend_lane({8'h00, byte_shifted[7:0]}, 1'b0, uns);
         end
         DM_HALF: begin
            misalign   = addr_lo[0];
            lane_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_word = {2{wdata[15:0]}};
            load_data  = extend_lane(half_sel, 1'b1, uns);
         end
         DM_WORD: begin
            misalign   = (addr_lo != 2'b00);
            lane_mask  = 4'b1111;
            store_word = wdata;
            load_data  = rword;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dm_wait.sv
// dm_wait
// Handshaked data memory with configurable wait states, byte/half/word
// access, sign/zero extension and fault reporting, plus a combinational
// debug read port.
// Parameters: DEPTH_WORDS (power of two), LATENCY (0..15 extra wait cycles).
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   req/we/size/uns     request and its attributes, held until ready
//   addr/wdata          byte address, right-aligned store data
//   rdata/ready/err     load result, one-cycle completion pulse, fault flag
//   busy                high from accept through the ready cycle
//   dbg_addr/dbg_data   word index and combinational read of that word

module dm_wait
   import dm_wait_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)
(
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           req,
   input  logic                           we,
   input  logic [1:0]                     size,
   input  logic                           uns,
   input  logic [31:0]                    addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata,
   output logic                           ready,
   output logic                           err,
   output logic                           busy,
   input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
   output logic [31:0]                    dbg_data
);

   localparam int              AW      = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

   dm_state_e         state;
   dm_state_e         next_state;
   logic [CNT_W-1:0]  cnt;
   dm_req_t           cap;
   dm_req_t           cur;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [AW-1:0]     word_idx;
   logic              out_of_range;
   logic              fault;
   logic              do_access;
   logic [31:0]       rword;
   logic [3:0]        lane_mask;
   logic [31:0]       store_word;
   logic [31:0]       load_data;
   logic              misalign;
   logic [31:0]       rdata_q;
   logic              err_q;

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. With zero latency the access goes straight to RESP.
   // WAIT leaves once the counter has counted down to 1; the <= also covers
   // a counter that somehow reached 0 so the FSM can never stick in WAIT.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (req) begin
               next_state = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt <= 4'd1) begin
               next_state = ST_RESP;
            end
         end
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Handshake outputs follow directly from the state.
   always_comb begin
      ready = (state == ST_RESP);
      busy  = (state != ST_IDLE);
   end

   // Capture the request on accept and load the wait counter; the counter
   // then ticks down once per WAIT cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cap <= '0;
         cnt <= '0;
      end else begin
         if (state == ST_IDLE && req) begin
            cap <= '{we: we, size: size, uns: uns, addr: addr, wdata: wdata};
            cnt <= LAT_CNT;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // The access happens on the edge that enters RESP. With zero latency that
   // is the accept edge itself, before the capture registers hold anything,
   // so the live inputs are used while still in IDLE.
   always_comb begin
      if (state == ST_IDLE) begin
         cur = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata};
      end else begin
         cur = cap;
      end
      do_access    = (next_state == ST_RESP) && (state != ST_RESP);
      word_idx     = cur.addr[AW+1:2];
      out_of_range = |cur.addr[31:AW+2];
      rword        = mem[word_idx];
      fault        = (cur.size == DM_RSVD) || misalign || out_of_range;
   end

   dm_lane_align u_lane_align (
      .size       (cur.size),
      .addr_lo    (cur.addr[1:0]),
      .wdata      (cur.wdata),
      .uns        (cur.uns),
      .rword      (rword),
      .lane_mask  (lane_mask),
      .store_word (store_word),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   // Memory array, deliberately not reset. Only the masked lanes of a good
   // store change; sampling rstn keeps a store from committing on an edge
   // that coincides with reset assertion.
   always_ff @(posedge clk) begin
      if (do_access && cur.we && !fault && rstn) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) begin
               mem[word_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
         end
      end
   end

   // Response registers: a faulted access or a store returns zero data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else if (do_access) begin
         err_q   <= fault;
         rdata_q <= (fault || cur.we) ? 32'h0000_0000 : load_data;
      end
   end

   assign rdata    = rdata_q;
   assign err      = err_q;
   assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_dm_wait.sv
// tb_dm_wait
// Drives four dm_wait instances (LATENCY 2, 0, 1, 15) and compares them
// against a byte-addressed memory model kept in the bench.

module tb_dm_wait;

   // Latency of each instance; instance 0 carries the directed and random tests
   function automatic int lat_of(input int g);
      case (g)
         0:       return 2;
         1:       return 0;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [3:0]  uns;
   logic [3:0]  ready;
   logic [3:0]  err;
   logic [3:0]  busy;
   logic [1:0]  size     [4];
   logic [31:0] addr     [4];
   logic [31:0] wdata    [4];
   logic [31:0] rdata    [4];
   logic [31:0] dbg_data [4];
   logic [9:0]  dbg_addr [4];

   int checks = 0;
   int fails  = 0;

   // Model memory: one byte per entry, keyed by instance and byte address
   logic [7:0] model_mem [int];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dm_wait #(
         .DEPTH_WORDS (1024),
         .LATENCY     (lat_of(g))
      ) u_dut (
         .clk      (clk),
         .rstn     (rstn),
         .req      (req[g]),
         .we       (we[g]),
         .size     (size[g]),
         .uns      (uns[g]),
         .addr     (addr[g]),
         .wdata    (wdata[g]),
         .rdata    (rdata[g]),
         .ready    (ready[g]),
         .err      (err[g]),
         .busy     (busy[g]),
         .dbg_addr (dbg_addr[g]),
         .dbg_data (dbg_data[g])
      );
   end

   // Single comparison point: counts, asserts and reports
   task automatic checkOutput(input int inst, input string tag,
                              input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s (dut%0d): observed 0x%08h, expected 0x%08h", tag, inst, obs, exp);
      end
   endtask

   function automatic int key(input int inst, input logic [31:0] a);
      return inst * 4096 + int'(a[11:0]);
   endfunction

   // Model view of a full word; known=0 if any byte was never written
   task automatic modelWord(input int inst, input logic [9:0] widx,
                            output logic [31:0] w, output bit known);
      int k;
      known = 1'b1;
      w     = 32'h0;
      for (int b = 0; b < 4; b++) begin
         k = inst * 4096 + int'(widx) * 4 + b;
         if (model_mem.exists(k)) w[8*b +: 8] = model_mem[k];
         else known = 1'b0;
      end
   endtask

   // Model load: gather bytes little-endian, then extend per size/uns
   task automatic modelLoad(input int inst, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, output logic [31:0] v, output bit known);
      logic [31:0] w;
      int          n;
      known = 1'b1;
      w     = 32'h0;
      n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) begin
         if (model_mem.exists(key(inst, a + 32'(i)))) w[8*i +: 8] = model_mem[key(inst, a + 32'(i))];
         else known = 1'b0;
      end
      if (sz == 2'd0)      v = u ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      else if (sz == 2'd1) v = u ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      else                 v = w;
   endtask

   // One complete access on an instance, checked against the model:
   // accept-to-ready gap, err, load data and the debug view of the word.
   task automatic applyStimulus(input int inst, input logic w, input logic [1:0] sz,
                                input logic u, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] got);
      int          n;
      int          nb;
      bit          fault;
      bit          known;
      logic [31:0] exp_v;
      fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
              || (a >= 32'd4096);
      @(negedge clk);
      we[inst]       = w;
      size[inst]     = sz;
      uns[inst]      = u;
      addr[inst]     = a;
      wdata[inst]    = wd;
      dbg_addr[inst] = a[11:2];
      req[inst]      = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready[inst] && n < 40);
      req[inst] = 1'b0;
      got       = rdata[inst];
      checkOutput(inst, "gap", 32'(n), 32'(lat_of(inst) + 1));
      checkOutput(inst, "err", 32'(err[inst]), 32'(fault));
      if (!w) begin
         if (fault) begin
            checkOutput(inst, "rdata_fault", rdata[inst], 32'h0);
         end else begin
            modelLoad(inst, sz, u, a, exp_v, known);
            if (known) checkOutput(inst, "rdata", rdata[inst], exp_v);
         end
      end
      if (w && !fault) begin
         nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         for (int i = 0; i < nb; i++) model_mem[key(inst, a + 32'(i))] = wd[8*i +: 8];
      end
      modelWord(inst, a[11:2], exp_v, known);
      if (known) checkOutput(inst, "dbg_word", dbg_data[inst], exp_v);
   endtask

   // Load with req held high across RESP: exactly one pulse per
   // LATENCY+2 cycles, so the second pulse comes from a fresh accept.
   task automatic heldReq(input int inst, input logic [31:0] a);
      int lat;
      int first;
      int second;
      int pulses;
      lat    = lat_of(inst);
      first  = 0;
      second = 0;
      pulses = 0;
      @(negedge clk);
      we[inst]   = 1'b0;
      size[inst] = 2'd2;
      uns[inst]  = 1'b0;
      addr[inst] = a;
      req[inst]  = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 2 * lat + 3; n++) begin
         @(negedge clk);
         if (ready[inst]) begin
            pulses++;
            if (first == 0) first = n;
            else second = n;
         end
      end
      req[inst] = 1'b0;
      checkOutput(inst, "held_first", 32'(first), 32'(lat + 1));
      checkOutput(inst, "held_spacing", 32'(second - first), 32'(lat + 2));
      checkOutput(inst, "held_pulses", 32'(pulses), 32'd2);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [31:0] exp_v;
      logic [1:0]  sz;
      bit          known;
      int          n;
      int          saw;

      // Reset with requests asserted on every instance: all are ignored
      rstn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req[i] = 1'b1; we[i] = 1'b0; uns[i] = 1'b0; size[i] = 2'd3;
         addr[i] = 32'h0; wdata[i] = 32'h0; dbg_addr[i] = 10'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checkOutput(i, "rst_ready", 32'(ready[i]), 32'd0);
         checkOutput(i, "rst_err",   32'(err[i]),   32'd0);
         checkOutput(i, "rst_rdata", rdata[i],      32'h0);
         checkOutput(i, "rst_busy",  32'(busy[i]),  32'd0);
      end

      // Release with req still held on dut0 (reserved size): accepted on the
      // first rising edge, faults with normal timing
      rstn   = 1'b1;
      req[1] = 1'b0; req[2] = 1'b0; req[3] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      checkOutput(0, "first_accept_busy", 32'(busy[0]), 32'd1);
      while (!ready[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      req[0] = 1'b0;
      checkOutput(0, "first_accept_gap", 32'(n), 32'd3);
      checkOutput(0, "rsvd_err", 32'(err[0]), 32'd1);
      checkOutput(0, "rsvd_rdata", rdata[0], 32'h0);

      // Give words 0..31 of dut0 known contents
      for (int i = 0; i < 32; i++) applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, got);

      // Word store then load
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
      checkOutput(0, "word_load", got, 32'hDEADBEEF);
      checkOutput(0, "dbg_word4", dbg_data[0], 32'hDEADBEEF);

      // Byte store into a word, then word / signed / unsigned byte loads
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, got);
      applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h00000080, got);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);
      checkOutput(0, "byte_merge", got, 32'h11803344);
      applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0, got);
      checkOutput(0, "byte_signed", got, 32'hFFFFFF80);
      applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h22, 32'h0, got);
      checkOutput(0, "byte_unsigned", got, 32'h00000080);

      // Half store into a cleared word, then signed half load
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h24, 32'h0, got);
      applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h26, 32'h0000ABCD, got);
      checkOutput(0, "half_word9", dbg_data[0], 32'hABCD0000);
      applyStimulus(0, 1'b0, 2'd1, 1'b0, 32'h26, 32'h0, got);
      checkOutput(0, "half_signed", got, 32'hFFFFABCD);

      // Faults: misaligned half store, misaligned/out-of-range word,
      // reserved size, load at the first out-of-range address
      applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, got);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, got);
      applyStimulus(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, got);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, got);
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, got);

      // Random mix over the initialised region, with occasional faults
      for (int i = 0; i < 40; i++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 127));
         if (sz != 2'd3 && $urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
            if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
         end
         if ($urandom_range(0, 9) == 0) a = a | 32'h0000_1000;
         applyStimulus(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
      end

      // Latency sweep and held-request behaviour on every instance
      for (int i = 0; i < 4; i++) begin
         applyStimulus(i, 1'b1, 2'd2, 1'b0, 32'h40, $urandom, got);
         applyStimulus(i, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, got);
         heldReq(i, 32'h40);
      end

      // Reset during the WAIT of a store: no pulse, no write
      applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h13579BDF, got);
      @(negedge clk);
      we[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h30; wdata[0] = 32'h5555AAAA;
      dbg_addr[0] = 10'd12; req[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput(0, "mid_busy", 32'(busy[0]), 32'd1);
      rstn   = 1'b0;
      req[0] = 1'b0;
      #1;
      checkOutput(0, "abort_busy", 32'(busy[0]), 32'd0);
      saw = 0;
      repeat (3) begin
         @(negedge clk);
         if (ready[0]) saw = 1;
      end
      rstn = 1'b1;
      checkOutput(0, "abort_no_ready", 32'(saw), 32'd0);
      modelWord(0, 10'd12, exp_v, known);
      checkOutput(0, "abort_word12", dbg_data[0], exp_v);
      applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, got);
      checkOutput(0, "after_abort_load", got, 32'h13579BDF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
